mips_multicycle_ctrl: RTL

- Moore control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the select lines of the datapath's 4:1 muxes (ALU operand B, PC source) and all write enables.
- Sits directly upstream of the mux4 instances; its select outputs connect to their s0/s1 inputs.

---
 rtl/mips_multicycle_ctrl_if.sv | 30 +++
 rtl/mips_multicycle_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller is the master: it reads op/zero and drives every select and enable.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic [3:0] state;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;

    modport master (
        input  op, zero,
        output state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen
    );

    modport slave (
        output op, zero,
        input  state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath; alusrcb/pcsrc feed the mux4 s1:s0 selects.
//
//  state    | meaning
//  ---------+--------------------------------------------
//  FETCH    | load IR, PC <= PC+4
//  DECODE   | read regs, precompute branch target
//  MEMADR   | ALU forms load/store address
//  MEMRD    | read data memory at ALUOut
//  MEMWB    | write MDR into rt
//  MEMWR    | write B to memory at ALUOut
//  EXECUTE  | R-type ALU operation
//  ALUWB    | write ALUOut into rd
//  BRANCH   | compare A-B, take branch on zero
//  ADDIEXEC | A + SignImm
//  ADDIWB   | write ALUOut into rt
//  JUMP     | PC <= jump target
module mips_multicycle_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t st;
    state_t st_nxt;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= FETCH;
        else      st <= st_nxt;
    end

    // Unknown opcodes fall back to FETCH, so they execute as a 2-cycle NOP.
    always_comb begin
        st_nxt = FETCH;
        case (st)
            FETCH:  st_nxt = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: st_nxt = MEMADR;
                    OP_RTYPE:     st_nxt = EXECUTE;
                    OP_BEQ:       st_nxt = BRANCH;
                    OP_ADDI:      st_nxt = ADDIEXEC;
                    OP_J:         st_nxt = JUMP;
                    default:      st_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW)      st_nxt = MEMRD;
                else if (bus.op == OP_SW) st_nxt = MEMWR;
                else                      st_nxt = FETCH;
            end
            MEMRD:    st_nxt = MEMWB;
            EXECUTE:  st_nxt = ALUWB;
            ADDIEXEC: st_nxt = ADDIWB;
            default:  st_nxt = FETCH;
        endcase
    end

    always_comb begin
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.aluop    = 2'b00;
        bus.pcsrc    = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        case (st)
            FETCH: begin
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
            end
            DECODE: bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            ADDIEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB: bus.regwrite = 1'b1;
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcen  = pcwrite | (branch & bus.zero);
    assign bus.state = st;
endmodule
